hist_seq_ctrl: RTL and testbench

HIST_SEQ_CTRL -- requirements
Module: hist_seq_ctrl

---
 rtl/hist_pkg.sv | 17 +
 rtl/hist_rmw_pipe.sv | 56 +++++
 rtl/hist_seq_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_hist_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared definitions for the histogram sequencer: FSM state encoding and
// default parameter values.
package hist_pkg;

    localparam int PIX_W_DEF     = 8;
    localparam int CNT_W_DEF     = 20;
    localparam int FRAME_PIX_DEF = 307200;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        DUMP
    } hist_state_e;

endpackage

// File: rtl/hist_rmw_pipe.sv
// Two-stage read-modify-write incrementer for the bin RAM, with forwarding of
// the previous cycle's write. Optional macro HIST_SAT_EN saturates the count.
module hist_rmw_pipe #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept_i,
    input  logic [PIX_W-1:0] pix_i,
    input  logic [CNT_W-1:0] rdata_i,
    output logic             wr_en_o,
    output logic [PIX_W-1:0] wr_addr_o,
    output logic [CNT_W-1:0] wr_data_o
);

    logic             s2_valid_q;
    logic [PIX_W-1:0] s2_addr_q;
    logic             prev_we_q;
    logic [PIX_W-1:0] prev_addr_q;
    logic [CNT_W-1:0] prev_data_q;
    logic             fwd;
    logic [CNT_W-1:0] operand;

    // Back-to-back hits on one bin would otherwise read a stale count.
    assign fwd     = prev_we_q && (prev_addr_q == s2_addr_q);
    assign operand = fwd ? prev_data_q : rdata_i;

`ifdef HIST_SAT_EN
    assign wr_data_o = (&operand) ? operand : operand + CNT_W'(1);
`else
    assign wr_data_o = operand + CNT_W'(1);
`endif

    assign wr_en_o   = s2_valid_q;
    assign wr_addr_o = s2_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_addr_q   <= '0;
            prev_we_q   <= 1'b0;
            prev_addr_q <= '0;
            prev_data_q <= '0;
        end else begin
            s2_valid_q  <= accept_i;
            if (accept_i) begin
                s2_addr_q <= pix_i;
            end
            prev_we_q   <= s2_valid_q;
            prev_addr_q <= s2_addr_q;
            prev_data_q <= wr_data_o;
        end
    end

endmodule

// File: rtl/hist_seq_ctrl.sv
// Histogram sequencer: clears the bin RAM, accumulates one frame of pixels,
// then streams all bins out. Honours HIST_SAT_EN through hist_rmw_pipe.
module hist_seq_ctrl
    import hist_pkg::*;
#(
    parameter int PIX_W     = PIX_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FRAME_PIX = FRAME_PIX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    output logic [PIX_W-1:0] mem_addr,
    output logic             mem_we,
    output logic [CNT_W-1:0] mem_wdata,
    input  logic [CNT_W-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_bin,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_last
);

    localparam int NBINS  = 2**PIX_W;
    localparam int PCNT_W = $clog2(FRAME_PIX + 1);

    hist_state_e       state_q, state_d;
    logic [PIX_W-1:0]  clr_addr_q, clr_addr_d;
    logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [PIX_W:0]    rd_addr_q, rd_addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              pf_valid_q, pf_valid_d;
    logic [CNT_W-1:0]  pf_cnt_q, pf_cnt_d;
    logic [PIX_W-1:0]  ld_bin_q, ld_bin_d;
    logic              out_valid_q, out_valid_d;
    logic [PIX_W-1:0]  out_bin_q, out_bin_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;

    logic             wr_en;
    logic [PIX_W-1:0] wr_addr;
    logic [CNT_W-1:0] wr_data;
    logic             accept;
    logic             hs;
    logic [1:0]       occ_after;
    logic             load;
    logic [CNT_W-1:0] load_cnt;
    logic             mem_we_c;

    // Single RAM port: a new pixel may only share the cycle with the pending
    // write when it hits the same bin (its count then comes from forwarding).
    assign pix_ready = (state_q == ACCUM) && !(wr_en && (pix_data != wr_addr));
    assign accept    = pix_valid && pix_ready;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_cnt   = out_cnt_q;
    assign out_last  = out_last_q;
    assign mem_we    = mem_we_c && !rst;

    assign hs        = out_valid_q && out_ready;
    assign occ_after = {1'b0, out_valid_q} + {1'b0, pf_valid_q} + {1'b0, rd_pend_q}
                       - {1'b0, hs};

    hist_rmw_pipe #(
        .PIX_W (PIX_W),
        .CNT_W (CNT_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .accept_i  (accept),
        .pix_i     (pix_data),
        .rdata_i   (mem_rdata),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data)
    );

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        pix_cnt_d   = pix_cnt_q;
        rd_addr_d   = rd_addr_q;
        rd_pend_d   = 1'b0;
        pf_valid_d  = pf_valid_q;
        pf_cnt_d    = pf_cnt_q;
        ld_bin_d    = ld_bin_q;
        out_valid_d = out_valid_q;
        out_bin_d   = out_bin_q;
        out_cnt_d   = out_cnt_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        load        = 1'b0;
        load_cnt    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                mem_we_c   = 1'b1;
                mem_addr   = clr_addr_q;
                clr_addr_d = clr_addr_q + PIX_W'(1);
                if (clr_addr_q == PIX_W'(NBINS - 1)) begin
                    state_d   = ACCUM;
                    pix_cnt_d = '0;
                end
            end
            ACCUM: begin
                if (wr_en) begin
                    mem_we_c  = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end else begin
                    mem_addr = pix_data;
                end
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + PCNT_W'(1);
                    if (pix_cnt_q == PCNT_W'(FRAME_PIX - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                mem_we_c    = wr_en;
                mem_addr    = wr_addr;
                mem_wdata   = wr_data;
                state_d     = DUMP;
                rd_addr_d   = '0;
                pf_valid_d  = 1'b0;
                ld_bin_d    = '0;
                out_valid_d = 1'b0;
            end
            DUMP: begin
                mem_addr = rd_addr_q[PIX_W-1:0];
                // Keep at most two counts in flight/held: output register + prefetch.
                if (!rd_addr_q[PIX_W] && (occ_after < 2'd2)) begin
                    rd_addr_d = rd_addr_q + (PIX_W+1)'(1);
                    rd_pend_d = 1'b1;
                end
                if (hs) begin
                    if (pf_valid_q) begin
                        load       = 1'b1;
                        load_cnt   = pf_cnt_q;
                        pf_valid_d = rd_pend_q;
                        pf_cnt_d   = mem_rdata;
                    end else if (rd_pend_q) begin
                        load     = 1'b1;
                        load_cnt = mem_rdata;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else if (rd_pend_q) begin
                    if (!out_valid_q) begin
                        load     = 1'b1;
                        load_cnt = mem_rdata;
                    end else begin
                        pf_valid_d = 1'b1;
                        pf_cnt_d   = mem_rdata;
                    end
                end
                if (load) begin
                    out_valid_d = 1'b1;
                    out_bin_d   = ld_bin_q;
                    out_cnt_d   = load_cnt;
                    out_last_d  = (ld_bin_q == PIX_W'(NBINS - 1));
                    ld_bin_d    = ld_bin_q + PIX_W'(1);
                end
                if (hs && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clr_addr_q  <= '0;
            pix_cnt_q   <= '0;
            rd_addr_q   <= '0;
            rd_pend_q   <= 1'b0;
            pf_valid_q  <= 1'b0;
            pf_cnt_q    <= '0;
            ld_bin_q    <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_cnt_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            pix_cnt_q   <= pix_cnt_d;
            rd_addr_q   <= rd_addr_d;
            rd_pend_q   <= rd_pend_d;
            pf_valid_q  <= pf_valid_d;
            pf_cnt_q    <= pf_cnt_d;
            ld_bin_q    <= ld_bin_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_cnt_q   <= out_cnt_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_hist_seq_ctrl.sv
// Directed bench for hist_seq_ctrl: main instance (FRAME_PIX=16, 20-bit bins)
// and a 4-bit-bin instance for the wrap/saturation case (HIST_SAT_EN aware).
module tb_hist_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       m_start, s_start;
    logic       pix_valid, out_ready;
    logic [7:0] pix_data;
    bit         sel;

    logic        m_busy, m_done, m_pix_ready, m_mem_we, m_out_valid, m_out_last;
    logic [7:0]  m_mem_addr, m_out_bin;
    logic [19:0] m_mem_wdata, m_mem_rdata, m_out_cnt;

    logic        s_busy, s_done, s_pix_ready, s_mem_we, s_out_valid, s_out_last;
    logic [7:0]  s_mem_addr, s_out_bin;
    logic [3:0]  s_mem_wdata, s_mem_rdata, s_out_cnt;

    hist_seq_ctrl #(.PIX_W(8), .CNT_W(20), .FRAME_PIX(16)) u_dut (
        .clk(clk), .rst(rst), .start(m_start), .busy(m_busy), .done(m_done),
        .pix_valid(pix_valid), .pix_ready(m_pix_ready), .pix_data(pix_data),
        .mem_addr(m_mem_addr), .mem_we(m_mem_we), .mem_wdata(m_mem_wdata),
        .mem_rdata(m_mem_rdata), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_bin(m_out_bin), .out_cnt(m_out_cnt), .out_last(m_out_last)
    );

    hist_seq_ctrl #(.PIX_W(8), .CNT_W(4), .FRAME_PIX(20)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .pix_valid(pix_valid), .pix_ready(s_pix_ready), .pix_data(pix_data),
        .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata),
        .mem_rdata(s_mem_rdata), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_bin(s_out_bin), .out_cnt(s_out_cnt), .out_last(s_out_last)
    );

    // Read-first RAM models
    logic [19:0] m_ram [256];
    logic [3:0]  s_ram [256];
    always @(posedge clk) begin
        m_mem_rdata <= m_ram[m_mem_addr];
        if (m_mem_we) m_ram[m_mem_addr] <= m_mem_wdata;
        s_mem_rdata <= s_ram[s_mem_addr];
        if (s_mem_we) s_ram[s_mem_addr] <= s_mem_wdata;
    end

    logic        w_busy, w_done, w_pix_ready, w_mem_we, w_out_valid, w_out_last;
    logic [7:0]  w_mem_addr, w_out_bin;
    logic [19:0] w_mem_wdata, w_out_cnt;
    assign w_busy      = sel ? s_busy      : m_busy;
    assign w_done      = sel ? s_done      : m_done;
    assign w_pix_ready = sel ? s_pix_ready : m_pix_ready;
    assign w_mem_we    = sel ? s_mem_we    : m_mem_we;
    assign w_out_valid = sel ? s_out_valid : m_out_valid;
    assign w_out_last  = sel ? s_out_last  : m_out_last;
    assign w_mem_addr  = sel ? s_mem_addr  : m_mem_addr;
    assign w_out_bin   = sel ? s_out_bin   : m_out_bin;
    assign w_mem_wdata = sel ? 20'(s_mem_wdata) : m_mem_wdata;
    assign w_out_cnt   = sel ? 20'(s_out_cnt)   : m_out_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_total = 0;
    int early_ov = 0;
    int phase = 0;
    int frame_cyc;
    int px_q[$];
    int gold[256];
    logic [19:0] got_h[256];

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (w_done) done_total++;
        if (w_out_valid && phase != 2) early_ov++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic start_seq(output int zero_wr);
        zero_wr = 0;
        if (sel) s_start = 1'b1; else m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        s_start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (w_pix_ready) break;
            if (w_mem_we && w_mem_wdata == 20'd0) zero_wr++;
            @(negedge clk);
        end
        if (!w_pix_ready) check("ready_timeout", 32'(w_pix_ready), 32'd1);
    endtask

    task automatic send_pix(input logic [7:0] v);
        bit ok = 1'b0;
        pix_valid = 1'b1;
        pix_data  = v;
        for (int t = 0; t < 8 && !ok; t++) begin
            #1;
            if (w_pix_ready) begin
                ok = 1'b1;
                @(posedge clk);
            end
            @(negedge clk);
        end
        if (!ok) check("pix_accept", 32'(w_pix_ready), 32'd1);
        pix_valid = 1'b0;
    endtask

    task automatic dump(input bit rnd);
        int beats = 0, stab_err = 0, order_err = 0, last_err = 0;
        bit stalled = 1'b0, fin = 1'b0, r;
        logic [7:0]  sb = '0;
        logic [19:0] sc = '0;
        logic        sl = 1'b0;
        for (int b = 0; b < 256; b++) got_h[b] = '0;
        for (int i = 0; i < 4000 && !fin; i++) begin
            if (stalled && (w_out_valid !== 1'b1 || w_out_bin !== sb ||
                            w_out_cnt !== sc || w_out_last !== sl)) stab_err++;
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (w_out_valid && r) begin
                got_h[w_out_bin] = w_out_cnt;
                if (int'(w_out_bin) != beats) order_err++;
                if (w_out_last != (w_out_bin == 8'hFF)) last_err++;
                beats++;
                if (w_out_last) fin = 1'b1;
            end
            stalled = w_out_valid && !r;
            sb = w_out_bin;
            sc = w_out_cnt;
            sl = w_out_last;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("dump_beats", 32'(beats), 32'd256);
        check("dump_order", 32'(order_err), 32'd0);
        check("dump_last", 32'(last_err), 32'd0);
        check("dump_stable", 32'(stab_err), 32'd0);
    endtask

    task automatic run_frame(input string nm, input bit rnd);
        int zw, c0, d0, mism, e, maxv;
        maxv = sel ? 15 : 20'hFFFFF;
        for (int b = 0; b < 256; b++) gold[b] = 0;
        d0 = done_total;
        phase = 1;
        start_seq(zw);
        check({nm, "_clear_writes"}, 32'(zw), 32'd256);
        c0 = cyc;
        foreach (px_q[k]) begin
            if (px_q[k] < 0) begin
                @(negedge clk);
            end else begin
                send_pix(8'(px_q[k]));
                gold[px_q[k]]++;
            end
        end
        frame_cyc = cyc - c0;
        phase = 2;
        dump(rnd);
        phase = 0;
        mism = 0;
        for (int b = 0; b < 256; b++) begin
`ifdef HIST_SAT_EN
            e = (gold[b] > maxv) ? maxv : gold[b];
`else
            e = gold[b] & maxv;
`endif
            if (int'(got_h[b]) != e) mism++;
        end
        check({nm, "_hist_mismatch"}, 32'(mism), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check({nm, "_done_pulses"}, 32'(done_total - d0), 32'd1);
        check({nm, "_busy_after"}, 32'(w_busy), 32'd0);
        check({nm, "_early_out_valid"}, 32'(early_ov), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int zw;
        rst = 1'b1; m_start = 1'b0; s_start = 1'b0;
        pix_valid = 1'b0; pix_data = '0; out_ready = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",      32'(w_busy), 32'd0);
        check("rst_done",      32'(w_done), 32'd0);
        check("rst_pix_ready", 32'(w_pix_ready), 32'd0);
        check("rst_mem_we",    32'(w_mem_we), 32'd0);
        check("rst_mem_addr",  32'(w_mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(w_mem_wdata), 32'd0);
        check("rst_out_valid", 32'(w_out_valid), 32'd0);
        check("rst_out_last",  32'(w_out_last), 32'd0);
        check("rst_out_bin",   32'(w_out_bin), 32'd0);
        check("rst_out_cnt",   32'(w_out_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 16 back-to-back pixels of value 7
        px_q = {};
        repeat (16) px_q.push_back(7);
        run_frame("f1", 1'b0);
        check("f1_b2b_cycles", 32'(frame_cyc), 32'd16);
        check("f1_bin7", 32'(got_h[7]), 32'd16);
        check("f1_bin8", 32'(got_h[8]), 32'd0);

        // Repeats, a bin change and a bubble; random backpressure on dump
        px_q = {3, 3, 5, -1, 3, 0, 0, 255, 255, 255, 9, 9, 1, 2, 9, 128, 128};
        run_frame("f2", 1'b1);
        check("f2_bin3", 32'(got_h[3]), 32'd3);
        check("f2_bin5", 32'(got_h[5]), 32'd1);
        check("f2_bin255", 32'(got_h[255]), 32'd3);

        // Abort mid-accumulate, then a clean frame
        phase = 1;
        start_seq(zw);
        send_pix(8'd9); send_pix(8'd9); send_pix(8'd4); send_pix(8'd4); send_pix(8'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy",      32'(w_busy), 32'd0);
        check("abort_mem_we",    32'(w_mem_we), 32'd0);
        check("abort_pix_ready", 32'(w_pix_ready), 32'd0);
        check("abort_out_valid", 32'(w_out_valid), 32'd0);
        px_q = {4, 4, 4, 9, 12, 12, 40, 40, 40, 40, 200, 201, 4, 9, 7, 7};
        run_frame("f3", 1'b1);
        check("f3_bin4", 32'(got_h[4]), 32'd4);
        check("f3_bin9", 32'(got_h[9]), 32'd2);

        // 4-bit counters, 20 hits on bin 0
        sel = 1'b1;
        px_q = {};
        repeat (20) px_q.push_back(0);
        run_frame("f4", 1'b0);
`ifdef HIST_SAT_EN
        check("f4_bin0", 32'(got_h[0]), 32'd15);
`else
        check("f4_bin0", 32'(got_h[0]), 32'd4);
`endif
        check("f4_bin1", 32'(got_h[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
